// File: rtl/seq_div16_pkg.sv
// Shared types and constants for the seq_div16 restoring divider.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = $clog2(DIV_W);

  localparam logic [DIV_W-1:0] DBZ_QUOT = 16'hFFFF;
  localparam logic [DIV_W-1:0] SMIN     = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_div16_if.sv
// Divide request/result bundle between the control unit (master) and seq_div16 (slave).
interface seq_div16_if
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
);

  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  logic         ovfl;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovfl
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovfl
  );

endinterface

// File: rtl/seq_div16_step.sv
// One restoring shift-subtract step: 17-bit trial subtract, yields next partial remainder and quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic [W-1:0] prem,
  input  logic         q_msb,
  input  logic [W-1:0] dmag,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);

  logic [W:0] trial;

  assign trial   = {prem, q_msb} - {1'b0, dmag};
  assign q_bit   = ~trial[W];
  assign rem_nxt = q_bit ? trial[W-1:0] : {prem[W-2:0], q_msb};

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle 16-bit restoring divider with start/busy/done handshake.
// Signed operation is built only when DIV_SIGNED_EN is defined.
module seq_div16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input logic        clk,
  input logic        rst_n,
  seq_div16_if.slave bus
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dmag;

  logic             busy_r, done_r, dbz_r, ovfl_r;
  logic [WIDTH-1:0] quot_r, rem_r;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nxt, q_nxt, q_fix, r_fix;
  logic             q_bit, ovfl_cap;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;

  div_step #(.W(WIDTH)) u_step (
    .prem    (prem),
    .q_msb   (q[WIDTH-1]),
    .dmag    (dmag),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_nxt = {q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, ovfl_pend;
  logic sgn_a, sgn_b;

  assign sgn_a = bus.is_signed & bus.dividend[WIDTH-1];
  assign sgn_b = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag = sgn_a ? ('0 - bus.dividend) : bus.dividend;
  assign b_mag = sgn_b ? ('0 - bus.divisor)  : bus.divisor;

  // Signs are latched at accept so the step datapath only ever sees magnitudes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovfl_pend <= 1'b0;
    end else if (accept) begin
      neg_q     <= sgn_a ^ sgn_b;
      neg_r     <= sgn_a;
      ovfl_pend <= bus.is_signed && (bus.dividend == SMIN) && (bus.divisor == '1);
    end
  end

  assign q_fix    = neg_q ? ('0 - q_nxt)   : q_nxt;
  assign r_fix    = neg_r ? ('0 - rem_nxt) : rem_nxt;
  assign ovfl_cap = ovfl_pend;
`else
  logic unused_sign;

  assign unused_sign = bus.is_signed;
  assign a_mag       = bus.dividend;
  assign b_mag       = bus.divisor;
  assign q_fix       = q_nxt;
  assign r_fix       = rem_nxt;
  assign ovfl_cap    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      prem   <= '0;
      q      <= '0;
      dmag   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      ovfl_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dbz_r  <= 1'b0;
            ovfl_r <= 1'b0;
            if (bus.divisor == '0) begin
              quot_r <= DBZ_QUOT;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              busy_r <= 1'b0;
              state  <= DONE;
            end else begin
              prem   <= '0;
              q      <= a_mag;
              dmag   <= b_mag;
              cnt    <= '1;
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prem <= rem_nxt;
          q    <= q_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            quot_r <= q_fix;
            rem_r  <= r_fix;
            ovfl_r <= ovfl_cap;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovfl      = ovfl_r;

endmodule
